// File: rtl/gpu_framebuffer_if.sv
// Framebuffer bus: GPU pixel-write port, bank-swap control and the raster scanout stream.
//   master: GPU / display side. Drives writes, swap_req, scan_start and scan_ready.
//   slave : framebuffer. Drives swap status and the scanout stream outputs.
interface gpu_framebuffer_if #(
    parameter int unsigned FB_WIDTH  = 400,
    parameter int unsigned FB_HEIGHT = 240
);
    localparam int unsigned XW = $clog2(FB_WIDTH) + 1;
    localparam int unsigned YW = $clog2(FB_HEIGHT) + 1;

    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;
    logic          swap_req;
    logic          swap_pending;
    logic          front_sel;
    logic          scan_start;
    logic [15:0]   scan_pixel;
    logic          scan_valid;
    logic          scan_ready;
    logic          scan_last;
    logic          scan_busy;

    modport master (
        output fb_x, fb_y, fb_color, fb_write, swap_req, scan_start, scan_ready,
        input  swap_pending, front_sel, scan_pixel, scan_valid, scan_last, scan_busy
    );

    modport slave (
        input  fb_x, fb_y, fb_color, fb_write, swap_req, scan_start, scan_ready,
        output swap_pending, front_sel, scan_pixel, scan_valid, scan_last, scan_busy
    );
endinterface

// File: rtl/gpu_framebuffer.sv
// Double-buffered framebuffer. GPU writes land in the back bank; scanout streams the front
// bank in raster order. A requested swap takes effect only at the next frame start.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - gpu_framebuffer_if.slave: write port, swap control, scanout valid/ready stream
module gpu_framebuffer #(
    parameter int unsigned FB_WIDTH  = 400,
    parameter int unsigned FB_HEIGHT = 240
) (
    input logic              clk,
    input logic              reset,
    gpu_framebuffer_if.slave bus
);
    localparam int unsigned NumPix = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned AddrW  = $clog2(NumPix);
    localparam int unsigned XW     = $clog2(FB_WIDTH) + 1;
    localparam int unsigned YW     = $clog2(FB_HEIGHT) + 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic swap_req_q, swap_pending_q, swap_pending_d, front_sel_q;
    logic swap_rise, do_swap;

    logic             wr_en;
    logic [AddrW-1:0] wr_addr;

    // One extra bit so the counter can reach NumPix ("nothing left to read").
    logic [AddrW:0]  rd_addr_q;
    logic            rd_en, inflight_q, rd_last_q;
    logic [15:0]     rd_data_q;

    logic [15:0] fifo_data_q [2];
    logic [15:0] fifo_data_d [2];
    logic        fifo_last_q [2];
    logic        fifo_last_d [2];
    logic [1:0]  occ_q, occ_d;
    logic        wr_idx;

    logic        out_valid, head_last, pop, pop_fifo, push, frame_done;
    logic [15:0] head_data;

    logic [15:0] mem0 [NumPix];
    logic [15:0] mem1 [NumPix];

    // ---------------- swap control ----------------
    assign swap_rise = bus.swap_req & ~swap_req_q;
    assign do_swap   = bus.scan_start & (swap_pending_q | swap_rise);

    always_comb begin
        swap_pending_d = swap_pending_q;
        if (do_swap) begin
            swap_pending_d = 1'b0;
        end else if (swap_rise) begin
            swap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_req_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            front_sel_q    <= 1'b0;
        end else begin
            swap_req_q     <= bus.swap_req;
            swap_pending_q <= swap_pending_d;
            if (do_swap) front_sel_q <= ~front_sel_q;
        end
    end

    // ---------------- banks ----------------
    assign wr_en   = bus.fb_write && (bus.fb_x < XW'(FB_WIDTH)) && (bus.fb_y < YW'(FB_HEIGHT));
    assign wr_addr = AddrW'(32'(bus.fb_y) * FB_WIDTH + 32'(bus.fb_x));

    // Write bank is the pre-edge back bank, read bank the pre-edge front bank; they never meet.
    always_ff @(posedge clk) begin
        if (wr_en && front_sel_q)  mem0[wr_addr] <= bus.fb_color;
        if (wr_en && !front_sel_q) mem1[wr_addr] <= bus.fb_color;
        if (rd_en) begin
            rd_data_q <= front_sel_q ? mem1[rd_addr_q[AddrW-1:0]] : mem0[rd_addr_q[AddrW-1:0]];
        end
    end

    // ---------------- scanout datapath ----------------
    // The in-flight read is presented directly when the FIFO is empty, so the first pixel
    // appears two cycles after scan_start and a stalled head simply migrates into the FIFO.
    assign out_valid  = (occ_q != 2'd0) | inflight_q;
    assign head_data  = (occ_q != 2'd0) ? fifo_data_q[0] : rd_data_q;
    assign head_last  = (occ_q != 2'd0) ? fifo_last_q[0] : rd_last_q;
    assign pop        = out_valid & bus.scan_ready;
    assign pop_fifo   = pop & (occ_q != 2'd0);
    assign push       = inflight_q & ~(pop & (occ_q == 2'd0));
    assign frame_done = pop & head_last;

    // A read is launched only if its data is guaranteed a slot.
    assign rd_en = (state_q == StActive) && !bus.scan_start
                && (rd_addr_q != (AddrW+1)'(NumPix))
                && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);

    assign wr_idx = pop_fifo ? (occ_q == 2'd2) : (occ_q != 2'd0);

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (pop_fifo) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
        end
        if (push) begin
            fifo_data_d[wr_idx] = rd_data_q;
            fifo_last_d[wr_idx] = rd_last_q;
        end
        occ_d = occ_q + 2'(push) - 2'(pop_fifo);
        if (bus.scan_start) occ_d = 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            occ_q       <= 2'd0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '{default: 1'b0};
        end else begin
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            occ_q       <= occ_d;
            if (bus.scan_start) begin
                rd_addr_q  <= '0;
                inflight_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end else begin
                inflight_q <= rd_en;
                if (rd_en) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    rd_last_q <= (rd_addr_q == (AddrW+1)'(NumPix - 1));
                end
            end
        end
    end

    // ---------------- scanout FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.scan_start) state_d = StActive;
            StActive: begin
                if (bus.scan_start)  state_d = StActive;
                else if (frame_done) state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.scan_busy = (state_q == StActive);
    end

    assign bus.scan_valid   = out_valid;
    assign bus.scan_pixel   = out_valid ? head_data : 16'h0000;
    assign bus.scan_last    = out_valid & head_last;
    assign bus.swap_pending = swap_pending_q;
    assign bus.front_sel    = front_sel_q;
endmodule

// File: tb/tb_gpu_framebuffer.sv
// Bench for gpu_framebuffer on a reduced 20x6 frame. A behavioural model tracks both banks,
// front selection, pending swap and the expected next pixel index; a negedge process checks
// every cycle against it. Directed phases add literal expectations.
module tb_gpu_framebuffer;
    localparam int W = 20;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gpu_framebuffer_if #(.FB_WIDTH(W), .FB_HEIGHT(H)) bus ();

    gpu_framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [15:0] mbank [2][N];
    logic [15:0] got [N];
    int   mfront, mpend, mbusy, exp_idx;
    bit   mprev, last_xfer, stall, rise;
    logic [15:0] stall_pix;
    logic        stall_last;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mfront = 0; mpend = 0; mbusy = 0; exp_idx = 0;
            mprev = 0; last_xfer = 0; stall = 0;
        end else begin
            rise  = bus.swap_req && !mprev;
            mprev = bus.swap_req;
            if (bus.fb_write && bus.fb_x < W && bus.fb_y < H)
                mbank[1 - mfront][int'(bus.fb_y) * W + int'(bus.fb_x)] = bus.fb_color;
            if (bus.scan_start) begin
                if (mpend != 0 || rise) begin
                    mfront = 1 - mfront;
                    mpend  = 0;
                end
                mbusy = 1; exp_idx = 0; stall = 0;
            end else begin
                if (rise) mpend = 1;
                if (last_xfer) mbusy = 0;
            end
            last_xfer = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("front_sel", 32'(bus.front_sel), mfront);
            chk("swap_pending", 32'(bus.swap_pending), mpend);
            chk("scan_busy", 32'(bus.scan_busy), mbusy);
            if (mbusy == 0) chk("valid_when_idle", 32'(bus.scan_valid), 0);
            if (stall) begin
                chk("stall_valid", 32'(bus.scan_valid), 1);
                chk("stall_pixel", 32'(bus.scan_pixel), 32'(stall_pix));
                chk("stall_last", 32'(bus.scan_last), 32'(stall_last));
            end
            stall      = bus.scan_valid && !bus.scan_ready;
            stall_pix  = bus.scan_pixel;
            stall_last = bus.scan_last;
            if (bus.scan_valid && bus.scan_ready) begin
                if (exp_idx >= N) begin
                    chk("xfer_overrun", exp_idx, N - 1);
                end else begin
                    chk("pixel", 32'(bus.scan_pixel), 32'(mbank[mfront][exp_idx]));
                    chk("last", 32'(bus.scan_last), 32'(exp_idx == N - 1));
                    got[exp_idx] = bus.scan_pixel;
                    if (exp_idx == N - 1) last_xfer = 1;
                    exp_idx++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input logic [15:0] c);
        bus.fb_x = 6'(x); bus.fb_y = 4'(y); bus.fb_color = c; bus.fb_write = 1'b1;
        tick();
        bus.fb_write = 1'b0;
    endtask

    task automatic swap_pulse();
        bus.swap_req = 1'b1; tick();
        bus.swap_req = 1'b0; tick();
    endtask

    task automatic start_pulse();
        bus.scan_start = 1'b1; tick();
        bus.scan_start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input bit full);
        bit done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.scan_busy) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) bus.scan_ready = ($urandom_range(0, 2) != 0);
        end
        bus.scan_ready = 1'b1;
        chk("idle_reached", 32'(done), 1);
        if (full) chk("frame_len", exp_idx, N);
        tick();
    endtask

    task automatic first_pixel(input string name, input logic [15:0] exp);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.scan_valid && bus.scan_ready) begin
                chk(name, 32'(bus.scan_pixel), 32'(exp));
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    int vcnt, lcnt, lpos;

    initial begin
        bus.fb_x = '0; bus.fb_y = '0; bus.fb_color = '0; bus.fb_write = 1'b0;
        bus.swap_req = 1'b0; bus.scan_start = 1'b0; bus.scan_ready = 1'b1;

        #3;
        chk("rst_front_sel", 32'(bus.front_sel), 0);
        chk("rst_swap_pending", 32'(bus.swap_pending), 0);
        chk("rst_scan_valid", 32'(bus.scan_valid), 0);
        chk("rst_scan_pixel", 32'(bus.scan_pixel), 0);
        chk("rst_scan_last", 32'(bus.scan_last), 0);
        chk("rst_scan_busy", 32'(bus.scan_busy), 0);
        #9 reset = 1'b1;
        tick();

        // Bank 1 (back): pattern addr^0x5A00, with (0,0)=0x1235.
        for (int a = 1; a < N; a++) wr(a % W, a / W, 16'(a) ^ 16'h5A00);
        wr(0, 0, 16'h1235);
        swap_pulse();
        chk("t1_pending_set", 32'(bus.swap_pending), 1);
        chk("t1_front_before", 32'(bus.front_sel), 0);
        start_pulse();
        chk("t1_front_after", 32'(bus.front_sel), 1);
        chk("t1_pending_clear", 32'(bus.swap_pending), 0);
        first_pixel("t1_first_pixel", 16'h1235);
        wait_idle(0, 1);

        // Bank 0 (back): pattern addr; out-of-bounds writes must be dropped.
        for (int a = 0; a < N; a++) wr(a % W, a / W, 16'(a));
        wr(20, 0, 16'hFFFF);
        wr(5, 6, 16'hFFFF);
        wr(63, 15, 16'hFFFF);
        swap_pulse();
        start_pulse();
        chk("t4_front", 32'(bus.front_sel), 0);
        wait_idle(1, 1);
        chk("t2_oob_x_dropped", 32'(got[20]), 20);
        chk("t4_first", 32'(got[0]), 0);
        chk("t4_last", 32'(got[N-1]), N - 1);

        // Constant ready: latency, throughput, single scan_last, busy drop.
        bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
        @(negedge clk);
        chk("t3_valid_c1", 32'(bus.scan_valid), 0);
        vcnt = 0; lcnt = 0; lpos = -1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_valid_c2_pixel", 32'(bus.scan_pixel), 0);
            if (bus.scan_valid) vcnt++;
            if (bus.scan_last) begin lcnt++; lpos = i; end
        end
        chk("t3_transfers", vcnt, N);
        chk("t3_last_count", lcnt, 1);
        chk("t3_last_pos", lpos, N - 1);
        @(negedge clk);
        chk("t3_busy_after", 32'(bus.scan_busy), 0);
        tick();

        // swap_req held high mid-frame counts once and waits for the next frame start.
        start_pulse();
        repeat (30) tick();
        bus.swap_req = 1'b1;
        repeat (10) tick();
        bus.swap_req = 1'b0;
        chk("t5_pending", 32'(bus.swap_pending), 1);
        chk("t5_front_hold", 32'(bus.front_sel), 0);
        wait_idle(0, 1);
        chk("t5_front_hold_idle", 32'(bus.front_sel), 0);
        start_pulse();
        chk("t5_front_toggled", 32'(bus.front_sel), 1);
        chk("t5_pending_clear", 32'(bus.swap_pending), 0);
        wait_idle(0, 1);
        chk("t5_bank1_px1", 32'(got[1]), 32'h5A01);
        start_pulse();
        chk("t5_single_toggle", 32'(bus.front_sel), 1);

        // Abort mid-frame: next transfer is pixel 0 of the (unchanged) front bank.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_idx >= 50) break;
        end
        chk("t6_reached_50", 32'(exp_idx >= 50), 1);
        @(posedge clk); #1;
        start_pulse();
        first_pixel("t6_restart_pixel", 16'h1235);
        repeat (20) tick();

        // Asynchronous reset mid-frame.
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.scan_valid), 0);
        chk("t6_rst_pixel", 32'(bus.scan_pixel), 0);
        chk("t6_rst_last", 32'(bus.scan_last), 0);
        chk("t6_rst_busy", 32'(bus.scan_busy), 0);
        chk("t6_rst_front", 32'(bus.front_sel), 0);
        chk("t6_rst_pending", 32'(bus.swap_pending), 0);
        #10 reset = 1'b1;
        tick();

        // RAM survives reset: bank 0 still holds the address pattern.
        start_pulse();
        first_pixel("post_rst_first", 16'h0000);
        wait_idle(0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpu_framebuffer.md
Name: gpu_framebuffer

Overview:
- Double-buffered framebuffer that terminates the GPU's framebuffer write interface (fb_x/fb_y/fb_color/fb_write).
- Serves raster-order pixel scanout to the display output path over a valid/ready stream.
- GPU writes always go to the back bank; scanout always reads the front bank.
- A swap request exchanges the two banks at the next frame start (vsync), so drawing never tears the displayed frame.

Parameters:
FB_WIDTH, 400, pixels per line
FB_HEIGHT, 240, lines per frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
fb_x  in  $clog2(FB_WIDTH)+1  write x coordinate
fb_y  in  $clog2(FB_HEIGHT)+1  write y coordinate
fb_color  in  16  write color
fb_write  in  1  write strobe, one pixel per cycle
swap_req  in  1  request bank swap, rising-edge detected
swap_pending  out  1  swap requested, not yet executed
front_sel  out  1  bank currently scanned out (0 or 1)
scan_start  in  1  frame-start pulse (vsync), one cycle
scan_pixel  out  16  scanout pixel data
scan_valid  out  1  scan_pixel valid
scan_ready  in  1  downstream accepts pixel
scan_last  out  1  qualifies final pixel of frame
scan_busy  out  1  frame scanout in progress

Behaviour:
- Reset (reset=0, asynchronous): front_sel=0, swap_pending=0, scan_valid=0, scan_pixel=0, scan_last=0, scan_busy=0.
  - Reset also clears the scan counters, the output buffer, the in-flight read and the swap_req edge register.
  - RAM contents are not reset.
- Storage: two banks, each FB_WIDTH*FB_HEIGHT x 16, inferred synchronous RAM.
  - Linear address = y*FB_WIDTH + x, width $clog2(FB_WIDTH*FB_HEIGHT).
- Write port: when fb_write=1, fb_x<FB_WIDTH and fb_y<FB_HEIGHT, fb_color is written to bank !front_sel at the next clk edge.
  - Out-of-bounds writes are dropped silently.
  - No backpressure; one write per cycle is sustained.
- Swap:
  - A swap_req 0->1 edge sets swap_pending. A held-high swap_req counts once.
  - Edges while pending are ignored.
  - On a scan_start cycle with swap_pending=1, or with a swap_req rising edge in that same cycle: front_sel toggles and swap_pending clears on that edge.
  - The new frame reads the new front bank.
  - A write in that same cycle goes to the old back bank (decided by front_sel before the edge).
- Scanout FSM, two states:
  - IDLE -> ACTIVE on scan_start. Counters are set to (0,0), buffer and in-flight read are flushed, scan_busy=1.
  - ACTIVE: reads are issued in raster order (x fastest; x wraps FB_WIDTH-1 -> 0 with y+1). RAM latency is 1 cycle.
  - Output is a 2-entry FIFO. A read is issued when (occupancy + in-flight) < 2 and pixels remain.
  - Sustained throughput is 1 pixel/cycle with scan_ready=1. First scan_valid is 2 cycles after scan_start.
  - Transfer occurs when scan_valid && scan_ready.
  - While scan_valid && !scan_ready, scan_pixel and scan_last hold stable.
  - scan_last=1 only with pixel (FB_WIDTH-1, FB_HEIGHT-1).
  - After the last transfer, ACTIVE -> IDLE and scan_busy=0 the next cycle.
  - scan_start during ACTIVE aborts the frame: flush, restart at (0,0), apply any pending swap. No stale pixel is emitted after the restart.
- Write and scanout never conflict, since they always use different banks.

Test Plan:
1. Reset, write (0,0)=0x1235 (lands in bank 1), pulse swap_req, pulse scan_start -> front_sel=1, swap_pending=0, first accepted pixel 0x1235.
2. Write x=400,y=0 color 0xFFFF; then swap+scan -> pixel at address 400, i.e. (0,1), keeps its prior value; no write occurs.
3. scan_ready=1 constant -> scan_valid rises 2 cycles after scan_start; exactly 96000 consecutive transfers; scan_last only on the 96000th; scan_busy=0 one cycle later.
4. Pre-fill the back bank with pixel = address[15:0], swap, scan with random scan_ready -> sequence 0,1,2,... with no loss or duplication; scan_pixel stable during stalls.
5. swap_req held high 10 cycles mid-frame -> swap_pending=1, front_sel unchanged until next scan_start, exactly one toggle.
6. scan_start at pixel 500 of a frame -> next transfer is pixel 0. Reset asserted mid-frame -> all outputs 0 immediately, without a clock.
